// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control logic.
package pipe_pkg;

    // Memory-wait controller states
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ERROR = 2'd2
    } hazState_t;

    // Register $zero never creates a true dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    // sll $0,$0,0 encodes as all zeros and is the canonical bubble
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Default width of the performance counters
    localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    // Count up on inc, hold once every bit is set, clear on reset or clr
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: turns load-use hazards, taken branches and
// slow data-memory accesses into PC/IF_ID enables and per-stage flush/hold
// controls, watches memory waits with a timeout FSM and keeps statistics.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_rt,
    input  logic             ex_mem_pcsrc,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             stage_hold,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    // Timer must be able to hold MEM_TIMEOUT-1
    localparam int TIMER_W = $clog2(MEM_TIMEOUT) + 1;

    hazState_t          r_state;
    logic [TIMER_W-1:0] r_timer;

    logic w_loadUse;
    logic w_memStall;
    logic w_incStall;
    logic w_incFlush;
    logic w_incWait;

    // A load in ID/EX writing a register the ID instruction reads
    assign w_loadUse = id_ex_memread && (id_ex_rt != REG_ZERO) &&
                       ((id_ex_rt == if_id_rs) ||
                        (if_id_uses_rt && (id_ex_rt == if_id_rt)));

    // A dropped request counts as completion, so it never holds the pipe
    assign w_memStall = mem_req && !mem_ready;

    // Mealy control outputs: memory freeze beats branch flush beats load-use
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_flush = 1'b0;
        stage_hold  = 1'b0;
        w_incStall  = 1'b0;
        w_incFlush  = 1'b0;
        w_incWait   = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_RUN, ST_WAIT: begin
                    if (w_memStall) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        stage_hold  = 1'b1;
                        w_incWait   = 1'b1;
                    end else if (ex_mem_pcsrc) begin
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                        w_incFlush   = 1'b1;
                    end else if (w_loadUse) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        w_incStall  = 1'b1;
                    end
                end
                default: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    stage_hold  = 1'b1;
                end
            endcase
        end
    end

    // State and wait timer; ERROR is left only through reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_timer <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_memStall) begin
                        r_state <= ST_WAIT;
                        r_timer <= TIMER_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (!w_memStall) begin
                        r_state <= ST_RUN;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                        if (r_timer == TIMER_W'(MEM_TIMEOUT - 1)) begin
                            r_state <= ST_ERROR;
                        end
                    end
                end
                default: begin
                    r_state <= ST_ERROR;
                end
            endcase
        end
    end

    assign err = (r_state == ST_ERROR);

    sat_counter #(.CNT_W(CNT_W)) u_stallCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_incStall),
        .clr   (1'b0),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flushCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_incFlush),
        .clr   (1'b0),
        .count (flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_waitCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_incWait),
        .clr   (1'b0),
        .count (wait_cnt)
    );

endmodule
